// File: rtl/demod_pkg.sv
// Shared definitions for the envelope demodulator.
//   DW       : default sample width
//   sample_t : signed input sample type
//   mag_t    : unsigned magnitude type (MSB always 0)
//   MAG_MAX  : largest representable magnitude, 2^(DW-1)-1
//   sat_abs(): saturating absolute value, -2^(DW-1) maps to MAG_MAX
package demod_pkg;

    localparam int DW = 16;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic        [DW-1:0] mag_t;

    localparam mag_t MAG_MAX = {1'b0, {(DW-1){1'b1}}};

    function automatic mag_t sat_abs(input sample_t x);
        if (x[DW-1]) begin
            // Most-negative value has no positive counterpart; clamp it.
            if (x[DW-2:0] == '0)
                return MAG_MAX;
            return mag_t'(-x);
        end
        return mag_t'(x);
    endfunction

endpackage

// File: rtl/demod_rectifier.sv
// Combinational saturating full-wave rectifier.
//   sample : signed two's-complement input, DW bits
//   mag    : |sample|, with -2^(DW-1) clamped to 2^(DW-1)-1
module demod_rectifier #(
    parameter int DW = demod_pkg::DW
) (
    input  logic [DW-1:0] sample,
    output logic [DW-1:0] mag
);

    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAG_LIM  = {1'b0, {(DW-1){1'b1}}};

    always_comb begin
        mag = sample;
        if (sample[DW-1]) begin
            if (sample == MOST_NEG)
                mag = MAG_LIM;
            else
                mag = -sample;
        end
    end

endmodule

// File: rtl/digital_demodulator.sv
// Envelope (AM) demodulator: saturating rectifier, optional single-pole IIR
// low-pass, registered output (1-cycle latency).
// Build option: define DEMOD_LPF_EN to enable the IIR smoother; otherwise the
// output is the registered rectifier magnitude.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   in_valid  : in_sample valid this cycle
//   in_sample : signed DW-bit input sample
//   out_valid : out_data updated this cycle
//   out_data  : DW-bit magnitude / envelope, MSB always 0
module digital_demodulator
    import demod_pkg::*;
#(
    parameter int DW        = demod_pkg::DW,
    parameter int LPF_SHIFT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_sample,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] mag;
    logic [DW-1:0] next_out;

    demod_rectifier #(
        .DW(DW)
    ) u_rect (
        .sample(in_sample),
        .mag   (mag)
    );

`ifdef DEMOD_LPF_EN
    // Fixed point: LPF_SHIFT fractional bits plus a sign bit above the magnitude.
    localparam int ACC_W = DW + LPF_SHIFT + 1;
    localparam logic signed [ACC_W-1:0] OUT_LIM =
        $signed({{(LPF_SHIFT+1){1'b0}}, 1'b0, {(DW-1){1'b1}}});

    logic signed [ACC_W-1:0] y_q;
    logic signed [ACC_W-1:0] mag_fp;
    logic signed [ACC_W-1:0] diff;
    logic signed [ACC_W-1:0] y_next;
    logic signed [ACC_W-1:0] y_int;

    always_comb begin
        mag_fp = $signed({1'b0, mag, {LPF_SHIFT{1'b0}}});
        diff   = mag_fp - y_q;
        y_next = y_q + (diff >>> LPF_SHIFT);
        // Output is the integer part of the post-update state, so latency stays 1.
        y_int  = y_next >>> LPF_SHIFT;
        if (y_int < 0)
            next_out = '0;
        else if (y_int > OUT_LIM)
            next_out = OUT_LIM[DW-1:0];
        else
            next_out = y_int[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            y_q <= '0;
        else if (in_valid)
            y_q <= y_next;
    end
`else
    always_comb begin
        next_out = mag;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= next_out;
        end
    end

endmodule

// File: tb/tb_digital_demodulator.sv
// Directed self-checking bench for digital_demodulator (both builds; the
// DEMOD_LPF_EN macro selects the smoother-specific checks).
module tb_digital_demodulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_sample;
    logic        out_valid;
    logic [15:0] out_data;

    int unsigned n_tests;
    int unsigned n_fail;

    digital_demodulator #(
        .DW       (16),
        .LPF_SHIFT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sample(in_sample),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input at the falling edge, then settle just after the rising edge.
    task automatic step(input logic v, input logic [15:0] s);
        @(negedge clk);
        in_valid  = v;
        in_sample = s;
        @(posedge clk);
        #1;
    endtask

`ifdef DEMOD_LPF_EN
    localparam logic [15:0] FRESH_EXP = 16'h0100;  // 0x1000 >> 4 after one update from y=0
`else
    localparam logic [15:0] FRESH_EXP = 16'h1000;
`endif

`ifndef DEMOD_LPF_EN
    logic [15:0] rect_in  [6] = '{16'h0000, 16'hFFFF, 16'h0005, 16'hFFFB, 16'h7FFF, 16'h8000};
    logic [15:0] rect_exp [6] = '{16'h0000, 16'h0001, 16'h0005, 16'h0005, 16'h7FFF, 16'h7FFF};
    logic        gate_v   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] gate_in  [4] = '{16'hFFFD, 16'h1234, 16'h4321, 16'h0009};
    logic [15:0] gate_exp [4] = '{16'h0003, 16'h0003, 16'h0003, 16'h0009};
`else
    int unsigned viol;
    logic [15:0] prev;
`endif

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;

        // 1. Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom));
        end
        check("rst_hold_data", {16'h0, out_data}, 32'h0);
        check("rst_hold_valid", {31'h0, out_valid}, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;

        // Asynchronous assertion in mid-cycle clears without a clock edge
        step(1'b1, 16'h7FFF);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_data", {16'h0, out_data}, 32'h0);
        check("rst_async_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

`ifndef DEMOD_LPF_EN
        // 2/3. Rectifier and saturation
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rect_in[i]);
            check($sformatf("rect_data[%0d]", i), {16'h0, out_data}, {16'h0, rect_exp[i]});
            check($sformatf("rect_valid[%0d]", i), {31'h0, out_valid}, 32'h1);
        end

        // 4. Valid gating, data holds through gaps
        for (int i = 0; i < 4; i++) begin
            step(gate_v[i], gate_in[i]);
            check($sformatf("gate_valid[%0d]", i), {31'h0, out_valid}, {31'h0, gate_v[i]});
            check($sformatf("gate_data[%0d]", i), {16'h0, out_data}, {16'h0, gate_exp[i]});
        end
`else
        // 5. Step response of 0x1000 from y=0
        viol = 0;
        prev = '0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 16'h1000);
            if (i == 0) begin
                check("lpf_first", {16'h0, out_data}, 32'h0100);
                check("lpf_first_valid", {31'h0, out_valid}, 32'h1);
            end
            if (out_data < prev)
                viol++;
            prev = out_data;
        end
        check("lpf_monotonic_violations", viol, 32'h0);
        check("lpf_settle", {31'h0, (out_data >= 16'h0FFF) && (out_data <= 16'h1000)}, 32'h1);

        // Alternating polarity has the same envelope
        for (int i = 0; i < 50; i++) begin
            step(1'b1, (i % 2 == 0) ? 16'hF000 : 16'h1000);
        end
        check("lpf_alt_settle", {31'h0, (out_data >= 16'h0FFF) && (out_data <= 16'h1000)}, 32'h1);

        // Gap: valid drops, no update
        step(1'b0, 16'h0000);
        check("lpf_gap_valid", {31'h0, out_valid}, 32'h0);
        check("lpf_gap_hold", {31'h0, (out_data >= 16'h0FFF) && (out_data <= 16'h1000)}, 32'h1);
`endif

        // 6. Reset mid-stream with a sample in flight
        step(1'b1, 16'h7000);
        step(1'b1, 16'h9000);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 16'h2345;
        rst = 1'b0;
        #1;
        check("mid_rst_data", {16'h0, out_data}, 32'h0);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_held_data", {16'h0, out_data}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        step(1'b0, 16'h5555);
        check("post_rst_idle_valid", {31'h0, out_valid}, 32'h0);
        check("post_rst_idle_data", {16'h0, out_data}, 32'h0);
        step(1'b1, 16'hF000);
        check("post_rst_first_data", {16'h0, out_data}, {16'h0, FRESH_EXP});
        check("post_rst_first_valid", {31'h0, out_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
